// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, constants and fetch FSM encodings for the instruction-fetch unit.
package if_fetch_unit_pkg;

  localparam int IF_ADDR_LEN   = 32;
  localparam int IF_INST_LEN   = 32;
  localparam int IF_INDEX_BITS = 7;

  localparam logic [IF_INST_LEN-1:0] ZERO_WORD = '0;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_WAIT  = 2'd2,
    FETCH_FLUSH = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_icache_dm.sv
// Direct-mapped instruction cache: combinational read port, synchronous write port.
module icache_dm
  import if_fetch_unit_pkg::*;
#(
  parameter int INDEX_BITS = IF_INDEX_BITS,
  parameter int TAG_BITS   = IF_ADDR_LEN - IF_INDEX_BITS - 2,
  parameter int DATA_BITS  = IF_INST_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [DATA_BITS-1:0]  rd_data_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [DATA_BITS-1:0]  wr_data_i
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0]  tag_mem  [ENTRIES];
  logic [DATA_BITS-1:0] data_mem [ENTRIES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en_i) valid_d[wr_index_i] = ENABLE;
  end

  // Only the valid bits are reset; tag/data contents are don't-care until valid.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_mem[wr_index_i]  <= wr_tag_i;
      data_mem[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_mem[rd_index_i];
  assign rd_data_o  = data_mem[rd_index_i];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: direct-mapped icache lookup on pc_i, byte-serial miss fill
// over the memory-controller port, one-cycle inst_ready_o pulse on fill completion.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_LEN   = IF_ADDR_LEN,
  parameter int INST_LEN   = IF_INST_LEN,
  parameter int INDEX_BITS = IF_INDEX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic [ADDR_LEN-1:0] pc_i,
  input  logic                pc_jump_enable_i,
  input  logic                stall_i,
  output logic                icache_hitted_o,
  output logic                inst_ready_o,
  output logic [INST_LEN-1:0] inst_o,
  output logic [ADDR_LEN-1:0] inst_pc_o,
  output logic                mem_req_o,
  output logic [ADDR_LEN-1:0] mem_addr_o,
  input  logic                mem_grant_i,
  input  logic [7:0]          mem_data_i,
  input  logic                mem_data_valid_i
);

  localparam int TAG_BITS = ADDR_LEN - INDEX_BITS - 2;

  fetch_state_e        state_q, state_d;
  logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [INST_LEN-1:0] word_q, word_d;
  logic                inst_ready_q, inst_ready_d;
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic [ADDR_LEN-1:0] inst_pc_q, inst_pc_d;

  logic [INDEX_BITS-1:0] rd_index;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [INST_LEN-1:0]   rd_data;
  logic                  line_match;
  logic                  cache_we;
  logic [INST_LEN-1:0]   fill_word;

  // stall_i is informational only and pc_i[1:0] is always zero.
  logic unused_inputs;
  assign unused_inputs = ^{stall_i, pc_i[1:0]};

  assign rd_index   = pc_i[INDEX_BITS+1:2];
  assign lookup_tag = pc_i[ADDR_LEN-1:INDEX_BITS+2];
  assign line_match = rd_valid && (rd_tag == lookup_tag);

  icache_dm #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_BITS  (INST_LEN)
  ) u_icache (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (rd_index),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (cache_we && rdy && !rst),
    .wr_index_i (fetch_pc_q[INDEX_BITS+1:2]),
    .wr_tag_i   (fetch_pc_q[ADDR_LEN-1:INDEX_BITS+2]),
    .wr_data_i  (fill_word)
  );

  // Memory handshake: a request (mem_req_o with mem_addr_o) is held stable until
  // mem_grant_i is seen in the same cycle; the byte then arrives with
  // mem_data_valid_i exactly one cycle later. No request is raised while rdy is low.
  assign mem_req_o  = rdy && !rst && (state_q == FETCH_REQ);
  assign mem_addr_o = (state_q == FETCH_REQ)
                      ? fetch_pc_q + {{(ADDR_LEN-2){1'b0}}, byte_cnt_q}
                      : '0;

  // Hits are suppressed in the completion cycle so the PC register sees one advance source.
  assign icache_hitted_o = !rst && (state_q == FETCH_IDLE) && !inst_ready_q && line_match;
  assign inst_ready_o    = inst_ready_q;
  assign inst_o          = icache_hitted_o ? rd_data : inst_q;
  assign inst_pc_o       = icache_hitted_o ? pc_i    : inst_pc_q;

  always_comb begin
    fill_word = word_q;
    fill_word[{byte_cnt_q, 3'b000} +: 8] = mem_data_i;
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    inst_ready_d = DISABLE;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    cache_we     = DISABLE;

    case (state_q)
      FETCH_IDLE: begin
        if (!line_match && !pc_jump_enable_i && !inst_ready_q) begin
          fetch_pc_d = pc_i;
          byte_cnt_d = 2'd0;
          word_d     = ZERO_WORD;
          state_d    = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (mem_grant_i) begin
          // A granted byte is still in flight, so a jump must drain it first.
          state_d = pc_jump_enable_i ? FETCH_FLUSH : FETCH_WAIT;
        end else if (pc_jump_enable_i) begin
          state_d = FETCH_IDLE;
        end
      end
      FETCH_WAIT: begin
        if (mem_data_valid_i) begin
          if (pc_jump_enable_i) begin
            state_d = FETCH_IDLE;
          end else if (byte_cnt_q != 2'd3) begin
            word_d     = fill_word;
            byte_cnt_d = byte_cnt_q + 2'd1;
            state_d    = FETCH_REQ;
          end else begin
            word_d       = fill_word;
            cache_we     = ENABLE;
            inst_d       = fill_word;
            inst_pc_d    = fetch_pc_q;
            inst_ready_d = ENABLE;
            state_d      = FETCH_IDLE;
          end
        end else if (pc_jump_enable_i) begin
          state_d = FETCH_FLUSH;
        end
      end
      FETCH_FLUSH: begin
        if (mem_data_valid_i) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_IDLE;
      fetch_pc_q   <= '0;
      byte_cnt_q   <= 2'd0;
      word_q       <= ZERO_WORD;
      inst_ready_q <= DISABLE;
      inst_q       <= ZERO_WORD;
      inst_pc_q    <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      inst_ready_q <= inst_ready_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: byte-wide memory responder, expected-word and
// expected-grant-address queues, immediate assertions at every comparison.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] pc_i;
  logic        pc_jump_enable_i;
  logic        stall_i;
  logic        icache_hitted_o;
  logic        inst_ready_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_grant_i;
  logic [7:0]  mem_data_i;
  logic        mem_data_valid_i;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  int lat;

  logic [63:0] exp_q[$];
  logic [31:0] addr_q[$];

  bit          grant_en = 1'b1;
  bit          inject_stray = 1'b0;
  bit          pend_valid = 1'b0;
  bit          ready_flag = 1'b0;
  logic [7:0]  pend_byte = 8'h00;
  logic [31:0] grant_addr = 32'h0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .pc_i             (pc_i),
    .pc_jump_enable_i (pc_jump_enable_i),
    .stall_i          (stall_i),
    .icache_hitted_o  (icache_hitted_o),
    .inst_ready_o     (inst_ready_o),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_grant_i      (mem_grant_i),
    .mem_data_i       (mem_data_i),
    .mem_data_valid_i (mem_data_valid_i)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0:   mem_byte = 8'h13;
      32'h1:   mem_byte = 8'h05;
      32'h2:   mem_byte = 8'h10;
      32'h3:   mem_byte = 8'h00;
      default: mem_byte = (a[7:0] * 8'd29) ^ {6'b0, a[9:8]} ^ 8'h5c;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    word_at = {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic push_fill(input logic [31:0] a, input logic [31:0] w);
    exp_q.push_back({a, w});
    for (int i = 0; i < 4; i++) addr_q.push_back(a + i);
  endtask

  // One clock: memory responses driven at negedge, outputs sampled 1ns after posedge.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    mem_grant_i      = grant_en && mem_req_o;
    mem_data_valid_i = pend_valid || inject_stray;
    mem_data_i       = pend_byte;
    if (mem_grant_i) begin
      check("grant_expected", 64'(addr_q.size() != 0), 64'd1);
      if (addr_q.size() != 0) check("grant_addr", 64'(mem_addr_o), 64'(addr_q.pop_front()));
      grant_addr = mem_addr_o;
    end
    @(posedge clk);
    #1;
    pend_valid       = mem_grant_i;
    pend_byte        = mem_byte(grant_addr);
    mem_grant_i      = 1'b0;
    mem_data_valid_i = 1'b0;
    inject_stray     = 1'b0;
    if (inst_ready_o) begin
      ready_cnt++;
      ready_flag = 1'b1;
      check("hit_forced_low_on_ready", 64'(icache_hitted_o), 64'd0);
      check("ready_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ready_inst", 64'(inst_o), 64'(e[31:0]));
        check("ready_pc", 64'(inst_pc_o), 64'(e[63:32]));
      end
    end
  endtask

  task automatic wait_ready(input int budget, output int n);
    ready_flag = 1'b0;
    n = 0;
    while (!ready_flag && n < budget) begin
      tick();
      n++;
    end
    check("ready_within_budget", 64'(ready_flag), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; pc_i = 32'h0; pc_jump_enable_i = 1'b0; stall_i = 1'b0;
    mem_grant_i = 1'b0; mem_data_i = 8'h00; mem_data_valid_i = 1'b0;
    tick();
    tick();
    check("rst_inst_ready", 64'(inst_ready_o), 64'd0);
    check("rst_mem_req", 64'(mem_req_o), 64'd0);
    check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    check("rst_inst", 64'(inst_o), 64'd0);
    check("rst_inst_pc", 64'(inst_pc_o), 64'd0);
    check("rst_hit", 64'(icache_hitted_o), 64'd0);
    rst = 1'b0;

    // First miss fill at 0x0; 1 IDLE cycle + 8 fill cycles before the pulse is sampled.
    stall_i = 1'b1;
    push_fill(32'h0, 32'h00100513);
    wait_ready(40, lat);
    check("fill_latency", 64'(lat), 64'd9);

    for (int i = 0; i < 3; i++) begin
      tick();
      check("hit_after_fill", 64'(icache_hitted_o), 64'd1);
      check("hit_inst", 64'(inst_o), 64'h00100513);
      check("hit_inst_pc", 64'(inst_pc_o), 64'h0);
      check("hit_no_req", 64'(mem_req_o), 64'd0);
    end
    stall_i = 1'b0;

    // Jump while byte 1 is being granted: FLUSH drains it, nothing written.
    pc_i = 32'h100;
    addr_q.push_back(32'h100);
    addr_q.push_back(32'h101);
    tick();
    check("req_raised", 64'(mem_req_o), 64'd1);
    check("req_addr_byte0", 64'(mem_addr_o), 64'h100);
    tick();
    tick();
    pc_jump_enable_i = 1'b1;
    tick();
    pc_jump_enable_i = 1'b0;
    pc_i = 32'h0;
    check("flush_no_req", 64'(mem_req_o), 64'd0);
    tick();
    check("after_flush_no_req", 64'(mem_req_o), 64'd0);
    check("after_flush_idle_hit", 64'(icache_hitted_o), 64'd1);
    tick();
    check("idle_no_req", 64'(mem_req_o), 64'd0);
    pc_i = 32'h100;
    #1;
    check("aborted_line_misses", 64'(icache_hitted_o), 64'd0);
    push_fill(32'h100, word_at(32'h100));
    wait_ready(40, lat);

    // Same-index conflict: 0x204 evicts 0x004.
    pc_i = 32'h004;
    push_fill(32'h004, word_at(32'h004));
    wait_ready(40, lat);
    pc_i = 32'h204;
    push_fill(32'h204, word_at(32'h204));
    wait_ready(40, lat);
    tick();
    check("conflict_new_hit", 64'(icache_hitted_o), 64'd1);
    check("conflict_new_inst", 64'(inst_o), 64'(word_at(32'h204)));
    pc_i = 32'h004;
    #1;
    check("conflict_old_misses", 64'(icache_hitted_o), 64'd0);

    // Grant backpressure, then rdy low mid-fill.
    grant_en = 1'b0;
    push_fill(32'h004, word_at(32'h004));
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("backpressure_req", 64'(mem_req_o), 64'd1);
      check("backpressure_addr", 64'(mem_addr_o), 64'h004);
    end
    grant_en = 1'b1;
    tick();
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rdy_low_no_req", 64'(mem_req_o), 64'd0);
      check("rdy_low_addr_stable", 64'(mem_addr_o), 64'h005);
    end
    rdy = 1'b1;
    #1;
    check("rdy_back_req", 64'(mem_req_o), 64'd1);
    wait_ready(40, lat);

    // Reset after two bytes with a third in flight, then a stray valid in IDLE.
    pc_i = 32'h300;
    tick();
    addr_q.push_back(32'h300);
    addr_q.push_back(32'h301);
    addr_q.push_back(32'h302);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    check("midfill_rst_ready", 64'(inst_ready_o), 64'd0);
    check("midfill_rst_req", 64'(mem_req_o), 64'd0);
    rst = 1'b0;
    pc_i = 32'h0;
    #1;
    check("rst_cleared_0x0", 64'(icache_hitted_o), 64'd0);
    pc_i = 32'h100;
    #1;
    check("rst_cleared_0x100", 64'(icache_hitted_o), 64'd0);
    pc_i = 32'h204;
    #1;
    check("rst_cleared_0x204", 64'(icache_hitted_o), 64'd0);
    pc_i = 32'h300;
    inject_stray = 1'b1;
    push_fill(32'h300, word_at(32'h300));
    tick();
    check("stray_ignored_req", 64'(mem_req_o), 64'd1);
    check("stray_ignored_addr", 64'(mem_addr_o), 64'h300);
    check("stray_no_ready", 64'(inst_ready_o), 64'd0);
    wait_ready(40, lat);

    tick();
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    check("addr_queue_drained", 64'(addr_q.size()), 64'd0);
    check("ready_pulse_count", 64'(ready_cnt), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
